// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the up/down modulo counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : updown_next_state
//  Description : Combinational next-count and event logic for the modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             carry_n,
    output logic             borrow_n,
    output logic             sat_n
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    always_comb begin
        next_count = count;
        carry_n    = 1'b0;
        borrow_n   = 1'b0;
        sat_n      = 1'b0;
        if (load) begin
            // Out-of-range loads clamp to the top state without any event.
            next_count = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (en) begin
            if (up) begin
                if (count < C_MAX) begin
                    next_count = count + WIDTH'(1);
                end else if (sat_mode == MODE_SAT) begin
                    sat_n = 1'b1;
                end else begin
                    next_count = '0;
                    carry_n    = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    next_count = count - WIDTH'(1);
                end else if (sat_mode == MODE_SAT) begin
                    sat_n = 1'b1;
                end else begin
                    next_count = C_MAX;
                    borrow_n   = 1'b1;
                end
            end
        end
    end

endmodule : updown_next_state
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Registered up/down modulo counter with Gray output and event pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             at_max,
    output logic             at_min,
    output logic             carry,
    output logic             borrow,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] w_next_count;
    logic             w_carry_n;
    logic             w_borrow_n;
    logic             w_sat_n;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_gray;
    logic             r_carry;
    logic             r_borrow;
    logic             r_sat_hit;

    updown_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_state (
        .count      (r_count),
        .en         (en),
        .up         (up),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_val   (load_val),
        .next_count (w_next_count),
        .carry_n    (w_carry_n),
        .borrow_n   (w_borrow_n),
        .sat_n      (w_sat_n)
    );

    // Gray is encoded from the next count so it lands on the same edge as count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_gray    <= '0;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_count   <= w_next_count;
            r_gray    <= w_next_count ^ (w_next_count >> 1);
            r_carry   <= w_carry_n;
            r_borrow  <= w_borrow_n;
            r_sat_hit <= w_sat_n;
        end
    end

    assign count   = r_count;
    assign gray    = r_gray;
    assign carry   = r_carry;
    assign borrow  = r_borrow;
    assign sat_hit = r_sat_hit;
    assign at_max  = (r_count == C_MAX);
    assign at_min  = (r_count == '0);

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_mod_counter
//  Description : Directed self-checking bench for the up/down modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic       a_en = 0, a_up = 0, a_sat = 0, a_load = 0;
    logic [3:0] a_load_val = '0;
    logic [3:0] a_count, a_gray;
    logic       a_at_max, a_at_min, a_carry, a_borrow, a_sat_hit;

    logic       b_en = 0, b_up = 0, b_sat = 0, b_load = 0;
    logic [1:0] b_load_val = '0;
    logic [1:0] b_count, b_gray;
    logic       b_at_max, b_at_min, b_carry, b_borrow, b_sat_hit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
        .clock(clock), .reset(reset), .en(a_en), .up(a_up), .sat_mode(a_sat),
        .load(a_load), .load_val(a_load_val), .count(a_count), .gray(a_gray),
        .at_max(a_at_max), .at_min(a_at_min), .carry(a_carry), .borrow(a_borrow),
        .sat_hit(a_sat_hit)
    );

    updown_mod_counter #(.WIDTH(2), .MODULUS(4)) u_dut_b (
        .clock(clock), .reset(reset), .en(b_en), .up(b_up), .sat_mode(b_sat),
        .load(b_load), .load_val(b_load_val), .count(b_count), .gray(b_gray),
        .at_max(b_at_max), .at_min(b_at_min), .carry(b_carry), .borrow(b_borrow),
        .sat_hit(b_sat_hit)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full observable state of the 4-bit / modulo-10 instance.
    task automatic check_a(input string tag, input int c, input bit cy, input bit bw, input bit sh);
        logic [3:0] c4;
        c4 = 4'(c);
        check_value({tag, ".count"},  32'(a_count),  32'(c4));
        check_value({tag, ".gray"},   32'(a_gray),   32'(c4 ^ (c4 >> 1)));
        check_value({tag, ".carry"},  32'(a_carry),  32'(cy));
        check_value({tag, ".borrow"}, 32'(a_borrow), 32'(bw));
        check_value({tag, ".sathit"}, 32'(a_sat_hit), 32'(sh));
        check_value({tag, ".atmax"},  32'(a_at_max), 32'(c == 9));
        check_value({tag, ".atmin"},  32'(a_at_min), 32'(c == 0));
    endtask

    task automatic check_b(input string tag, input int c, input bit cy, input bit bw);
        logic [1:0] c2;
        c2 = 2'(c);
        check_value({tag, ".count"},  32'(b_count),  32'(c2));
        check_value({tag, ".gray"},   32'(b_gray),   32'(c2 ^ (c2 >> 1)));
        check_value({tag, ".carry"},  32'(b_carry),  32'(cy));
        check_value({tag, ".borrow"}, 32'(b_borrow), 32'(bw));
        check_value({tag, ".atmax"},  32'(b_at_max), 32'(c == 3));
        check_value({tag, ".atmin"},  32'(b_at_min), 32'(c == 0));
    endtask

    task automatic load_a(input logic [3:0] v);
        a_load = 1; a_load_val = v;
        tick();
        a_load = 0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check_a("rst_async", 0, 0, 0, 0);
        check_b("rst_async_b", 0, 0, 0);
        tick();
        check_a("rst_held", 0, 0, 0, 0);
        #2 reset = 1'b0;

        // Wrap up through 9 -> 0 -> 2
        a_en = 1; a_up = 1; a_sat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_a($sformatf("wrap_up%0d", i), i % 10, (i == 10), 0, 0);
            if (i == 9) check_value("gray9", 32'(a_gray), 32'(4'b1101));
        end

        // Wrap down 0 -> 9 -> 8
        load_a(4'd0);
        check_a("load0", 0, 0, 0, 0);
        a_up = 0;
        tick(); check_a("wrap_dn1", 9, 0, 1, 0);
        tick(); check_a("wrap_dn2", 8, 0, 0, 0);

        // Saturate at top, then step down
        a_en = 0;
        load_a(4'd9);
        check_a("load9", 9, 0, 0, 0);
        a_en = 1; a_up = 1; a_sat = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_a($sformatf("sat_up%0d", i), 9, 0, 0, 1);
        end
        a_up = 0;
        tick(); check_a("sat_release", 8, 0, 0, 0);

        // Saturate at bottom
        a_en = 0;
        load_a(4'd0);
        a_en = 1; a_up = 0;
        tick(); check_a("sat_dn", 0, 0, 0, 1);

        // Load priority and clamp
        a_sat = 0; a_up = 1; a_en = 1;
        a_load = 1; a_load_val = 4'd13;
        tick(); check_a("load_clamp", 9, 0, 0, 0);
        a_load_val = 4'd3;
        tick(); check_a("load3", 3, 0, 0, 0);
        a_load_val = 4'd15;
        tick(); check_a("load_clamp15", 9, 0, 0, 0);
        a_load = 0;

        // Enable hold
        a_en = 0;
        load_a(4'd5);
        for (int i = 0; i < 5; i++) begin
            a_up = i[0];
            tick(); check_a($sformatf("hold%0d", i), 5, 0, 0, 0);
        end

        // Reset mid-count, asynchronously between edges
        load_a(4'd7);
        check_a("pre_rst", 7, 0, 0, 0);
        #3 reset = 1'b1;
        #1 check_a("mid_rst", 0, 0, 0, 0);
        #2 reset = 1'b0;

        // Reset clears a pending carry pulse
        load_a(4'd9);
        a_en = 1; a_up = 1; a_sat = 0;
        tick(); check_a("carry_pend", 0, 1, 0, 0);
        a_en = 0;
        #2 reset = 1'b1;
        #1 check_a("rst_clr_carry", 0, 0, 0, 0);
        #2 reset = 1'b0;

        // Full-range instance: wrap is natural overflow, pulses still fire
        b_en = 1; b_up = 1; b_sat = 0;
        for (int i = 1; i <= 4; i++) begin
            tick(); check_b($sformatf("b_up%0d", i), i % 4, (i == 4), 0);
        end
        b_up = 0;
        for (int i = 1; i <= 4; i++) begin
            tick(); check_b($sformatf("b_dn%0d", i), (4 - i) % 4, 0, (i == 1));
        end
        b_en = 0;
        tick(); check_b("b_hold", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_updown_mod_counter
`default_nettype wire

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised up/down counter FSM: counts modulo MODULUS in a WIDTH-bit state register, i.e. a general-width, general-modulus successor to the team's fixed 4-state up/down counter.
- Adds count enable, synchronous parallel load, selectable wrap/saturate mode, registered carry/borrow/saturation event pulses and a Gray-coded state output.
- Used as a step/position counter feeding display and sequencing logic.

Parameters:
- WIDTH, 4, state register width in bits.
- MODULUS, 10, number of states; count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration-time error otherwise.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; no step when 0
- up  in  1  direction: 1 = increment, 0 = decrement
- sat_mode  in  1  0 = wrap at bounds, 1 = saturate at bounds
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current state (registered)
- gray  out  WIDTH  Gray code of count (registered, same cycle as count)
- at_max  out  1  count == MODULUS-1 (combinational from count)
- at_min  out  1  count == 0 (combinational from count)
- carry  out  1  1-cycle pulse: wrap MODULUS-1 -> 0
- borrow  out  1  1-cycle pulse: wrap 0 -> MODULUS-1
- sat_hit  out  1  1-cycle pulse: step blocked by saturation

Behaviour:
- Reset (async, active-high): count=0, gray=0, carry=borrow=sat_hit=0. Held while reset=1. First update happens on the first rising edge after deassertion.
- Priority per rising edge: load > en > hold.
- load=1: count <= min(load_val, MODULUS-1). Clamping is silent. No pulses fire that cycle, and en/up are ignored.
- en=1, up=1, count<MODULUS-1: count <= count+1.
- en=1, up=1, count==MODULUS-1:
  - sat_mode=0: count <= 0, carry=1 next cycle.
  - sat_mode=1: count held, sat_hit=1 next cycle.
- en=1, up=0, count>0: count <= count-1.
- en=1, up=0, count==0:
  - sat_mode=0: count <= MODULUS-1, borrow=1 next cycle.
  - sat_mode=1: count held, sat_hit=1 next cycle.
- en=0 and load=0: count held; all pulses 0.
- Pulses are registered alongside count. They are high for exactly the one cycle in which the new count is visible, and are cleared on every other edge.
- gray <= next_count ^ (next_count >> 1), registered in the same edge as count, so gray always matches count.
- Latency: one clock from inputs to count/gray/pulses. at_max/at_min have zero latency relative to count.
- Arithmetic is unsigned, WIDTH bits. The next-state compare uses MODULUS-1, never 2**WIDTH-1, so states >= MODULUS are unreachable.
- When MODULUS == 2**WIDTH, wrap equals natural overflow; pulses still fire.
- up and sat_mode may change every cycle; only values sampled at the edge matter.
- Reset asserted mid-count: count immediately 0, any pending pulse cleared.

Decomposition:
- Shared package (counter_pkg): mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
- Sub-module: updown_next_state, combinational. Inputs count, en, up, sat_mode, load, load_val. Outputs next_count, carry_n, borrow_n, sat_n. The top is a register stage plus Gray encoding and the flags.

Test Plan:
- Reset mid-count: count=7, assert reset asynchronously between edges -> count=0, gray=0 without waiting for an edge; carry=0.
- Wrap up: WIDTH=4, MODULUS=10, sat_mode=0, en=1, up=1 for 12 edges from 0 -> count 1..9,0,1,2. carry high only in the cycle count==0. gray sequence matches count^(count>>1), e.g. 9 -> 4'b1101.
- Wrap down: count=0, up=0, en=1 -> count=9, borrow=1 one cycle. Next edge count=8, borrow=0.
- Saturate: sat_mode=1, count=9, up=1, en=1 for 3 edges -> count stays 9, sat_hit=1 each cycle, carry=0. Flip up=0 -> count=8, sat_hit=0.
- Load priority and clamp: load=1, load_val=4'd13, en=1, up=1 -> count=9 (clamped), no pulses, at_max=1. load_val=3 -> count=3.
- Enable hold: en=0, up toggling for 5 edges from count=5 -> count remains 5, all pulses 0. Second config WIDTH=2, MODULUS=4 runs a full up/down cycle, checking carry on 3->0 and borrow on 0->3.
